// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encodings,
// opcode constants, datapath select codes and the control-word payload.
package mc_control_unit_pkg;

   typedef enum logic [3:0] {
      S_IF,
      S_ID,
      S_EXE_R,
      S_EXE_I,
      S_EXE_M,
      S_EXE_BR,
      S_EXE_J,
      S_MEM_RD,
      S_MEM_WR,
      S_WB_R,
      S_WB_I,
      S_WB_LD,
      S_HALT
   } state_e;

   typedef enum logic [3:0] {
      OPC_R,
      OPC_I_ARITH,
      OPC_LW,
      OPC_SW,
      OPC_BEQ,
      OPC_BNE,
      OPC_J,
      OPC_HALT,
      OPC_ILLEGAL
   } op_class_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   localparam logic [1:0] ALU_B_REG     = 2'b00;
   localparam logic [1:0] ALU_B_FOUR    = 2'b01;
   localparam logic [1:0] ALU_B_SEXT    = 2'b10;
   localparam logic [1:0] ALU_B_SEXT_SH = 2'b11;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OP_OR    = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_src;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       i_or_d;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_dst;
      logic       wb_src;
      logic       reg_write;
      logic       instr_done;
      logic       illegal_op;
      logic       halted;
   } ctrl_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational classification of the IR opcode field into instruction classes.
module mc_opcode_decode
   import mc_control_unit_pkg::*;
#(
   parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
   input  logic [5:0] opcode,
   output op_class_e  op_class
);

   // Architected opcodes win over a halt opcode configured onto one of them.
   always_comb begin
      op_class = OPC_ILLEGAL;
      case (opcode)
         OP_RTYPE:        op_class = OPC_R;
         OP_ADDI, OP_ORI: op_class = OPC_I_ARITH;
         OP_LW:           op_class = OPC_LW;
         OP_SW:           op_class = OPC_SW;
         OP_BEQ:          op_class = OPC_BEQ;
         OP_BNE:          op_class = OPC_BNE;
         OP_J:            op_class = OPC_J;
         default:         op_class = (opcode == HALT_OPCODE) ? OPC_HALT : OPC_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM with cycle/retired-instruction counters.
// Optional memory handshake stalls enabled by defining MC_CTRL_STALL_EN.
module mc_control_unit
   import mc_control_unit_pkg::*;
#(
   parameter int unsigned CNT_W       = 32,
   parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             ir_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             i_or_d,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_dst,
   output logic             wb_src,
   output logic             reg_write,
   output logic             instr_done,
   output logic             illegal_op,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   state_e    state_q, state_d;
   op_class_e id_class, class_q;
   logic      ori_q;
   logic      mem_ok;
   ctrl_t     ctrl_raw, ctrl;

`ifdef MC_CTRL_STALL_EN
   assign mem_ok = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign mem_ok           = 1'b1;
`endif

   mc_opcode_decode #(
      .HALT_OPCODE (HALT_OPCODE)
   ) u_opcode_decode (
      .opcode   (opcode),
      .op_class (id_class)
   );

   // State, latched instruction class and counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IF;
         class_q   <= OPC_ILLEGAL;
         ori_q     <= 1'b0;
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_ID) begin
            class_q <= id_class;
            ori_q   <= (opcode == OP_ORI);
         end
         if (state_q != S_HALT)
            cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (ctrl_raw.instr_done)
            instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end

   // Next-state and Moore control decode.
   always_comb begin
      state_d  = state_q;
      ctrl_raw = '0;
      case (state_q)
         S_IF: begin
            ctrl_raw.mem_read  = 1'b1;
            ctrl_raw.alu_src_b = ALU_B_FOUR;
            ctrl_raw.pc_src    = PC_SRC_ALU;
            ctrl_raw.ir_write  = mem_ok;
            ctrl_raw.pc_write  = mem_ok;
            if (mem_ok)
               state_d = S_ID;
         end
         S_ID: begin
            ctrl_raw.alu_src_b = ALU_B_SEXT_SH;
            case (id_class)
               OPC_R:            state_d = S_EXE_R;
               OPC_I_ARITH:      state_d = S_EXE_I;
               OPC_LW, OPC_SW:   state_d = S_EXE_M;
               OPC_BEQ, OPC_BNE: state_d = S_EXE_BR;
               OPC_J:            state_d = S_EXE_J;
               OPC_HALT:         state_d = S_HALT;
               default: begin
                  ctrl_raw.illegal_op = 1'b1;
                  ctrl_raw.instr_done = 1'b1;
                  state_d             = S_IF;
               end
            endcase
         end
         S_EXE_R: begin
            ctrl_raw.alu_src_a = 1'b1;
            ctrl_raw.alu_op    = ALU_OP_FUNCT;
            state_d            = S_WB_R;
         end
         S_EXE_I: begin
            ctrl_raw.alu_src_a = 1'b1;
            ctrl_raw.alu_src_b = ALU_B_SEXT;
            ctrl_raw.alu_op    = ori_q ? ALU_OP_OR : ALU_OP_ADD;
            state_d            = S_WB_I;
         end
         S_EXE_M: begin
            ctrl_raw.alu_src_a = 1'b1;
            ctrl_raw.alu_src_b = ALU_B_SEXT;
            state_d            = (class_q == OPC_SW) ? S_MEM_WR : S_MEM_RD;
         end
         S_EXE_BR: begin
            ctrl_raw.alu_src_a  = 1'b1;
            ctrl_raw.alu_op     = ALU_OP_SUB;
            ctrl_raw.pc_src     = PC_SRC_BRANCH;
            ctrl_raw.pc_write   = (class_q == OPC_BEQ) ? zero : ~zero;
            ctrl_raw.instr_done = 1'b1;
            state_d             = S_IF;
         end
         S_EXE_J: begin
            ctrl_raw.pc_write   = 1'b1;
            ctrl_raw.pc_src     = PC_SRC_JUMP;
            ctrl_raw.instr_done = 1'b1;
            state_d             = S_IF;
         end
         S_MEM_RD: begin
            ctrl_raw.mem_read = 1'b1;
            ctrl_raw.i_or_d   = 1'b1;
            if (mem_ok)
               state_d = S_WB_LD;
         end
         S_MEM_WR: begin
            ctrl_raw.mem_write  = 1'b1;
            ctrl_raw.i_or_d     = 1'b1;
            ctrl_raw.instr_done = mem_ok;
            if (mem_ok)
               state_d = S_IF;
         end
         S_WB_R: begin
            ctrl_raw.reg_write  = 1'b1;
            ctrl_raw.reg_dst    = 1'b1;
            ctrl_raw.instr_done = 1'b1;
            state_d             = S_IF;
         end
         S_WB_I: begin
            ctrl_raw.reg_write  = 1'b1;
            ctrl_raw.instr_done = 1'b1;
            state_d             = S_IF;
         end
         S_WB_LD: begin
            ctrl_raw.reg_write  = 1'b1;
            ctrl_raw.wb_src     = 1'b1;
            ctrl_raw.instr_done = 1'b1;
            state_d             = S_IF;
         end
         S_HALT: begin
            ctrl_raw.halted = 1'b1;
         end
         default: begin
            state_d = S_IF;
         end
      endcase
   end

   // Reset masks every strobe at once so an abandoned instruction cannot write.
   assign ctrl = reset ? '0 : ctrl_raw;

   assign pc_write   = ctrl.pc_write;
   assign pc_src     = ctrl.pc_src;
   assign ir_write   = ctrl.ir_write;
   assign mem_read   = ctrl.mem_read;
   assign mem_write  = ctrl.mem_write;
   assign i_or_d     = ctrl.i_or_d;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign alu_op     = ctrl.alu_op;
   assign reg_dst    = ctrl.reg_dst;
   assign wb_src     = ctrl.wb_src;
   assign reg_write  = ctrl.reg_write;
   assign instr_done = ctrl.instr_done;
   assign illegal_op = ctrl.illegal_op;
   assign halted     = ctrl.halted;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed scoreboard bench for mc_control_unit: per-cycle expected control words
// are queued per instruction and compared against the DUT outputs each cycle.
module tb_mc_control_unit;

   localparam int unsigned CNT_W = 32;

   logic             clk;
   logic             reset;
   logic [5:0]       opcode;
   logic             zero;
   logic             mem_ready;
   logic             pc_write;
   logic [1:0]       pc_src;
   logic             ir_write;
   logic             mem_read;
   logic             mem_write;
   logic             i_or_d;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       alu_op;
   logic             reg_dst;
   logic             wb_src;
   logic             reg_write;
   logic             instr_done;
   logic             illegal_op;
   logic             halted;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] instr_cnt;

   mc_control_unit #(
      .CNT_W       (CNT_W),
      .HALT_OPCODE (6'b111111)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .ir_write   (ir_write),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .i_or_d     (i_or_d),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .reg_dst    (reg_dst),
      .wb_src     (wb_src),
      .reg_write  (reg_write),
      .instr_done (instr_done),
      .illegal_op (illegal_op),
      .halted     (halted),
      .cycle_cnt  (cycle_cnt),
      .instr_cnt  (instr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [17:0] obs_cw;
   assign obs_cw = {pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d, alu_src_a,
                    alu_src_b, alu_op, reg_dst, wb_src, reg_write, instr_done, illegal_op, halted};

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_cycles = 0;
   int exp_instr  = 0;

   logic [17:0] exp_q[$];
   logic        mr_q[$];
   string       tag_q[$];

   logic [17:0] V_IF, V_IF_ST, V_ID, V_ID_ILL, V_EXE_R, V_EXE_ADD, V_EXE_ORI, V_EXE_M;
   logic [17:0] V_BR_T, V_BR_N, V_J, V_MEM_RD, V_MEM_WR, V_MEM_WR_ST;
   logic [17:0] V_WB_R, V_WB_I, V_WB_LD, V_HALT;

   function automatic logic [17:0] cw(input logic pw, input logic [1:0] ps, input logic irw,
                                      input logic mr, input logic mw, input logic iod,
                                      input logic asa, input logic [1:0] asb, input logic [1:0] aop,
                                      input logic rd, input logic wbs, input logic rw,
                                      input logic dn, input logic il, input logic hl);
      return {pw, ps, irw, mr, mw, iod, asa, asb, aop, rd, wbs, rw, dn, il, hl};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_step(input logic [17:0] v, input logic mr, input string tag);
      exp_q.push_back(v);
      mr_q.push_back(mr);
      tag_q.push_back(tag);
   endtask

   // Entered and left at 1 time unit after a rising edge.
   task automatic drain(input logic [5:0] late_op, input int late_at);
      int i;
      i = 0;
      while (exp_q.size() > 0) begin
         logic [17:0] e;
         string       t;
         e         = exp_q.pop_front();
         t         = tag_q.pop_front();
         mem_ready = mr_q.pop_front();
         if (i == late_at)
            opcode = late_op;
         #1;
         check(t, 32'(obs_cw), 32'(e));
         if (!e[0]) exp_cycles++;
         if (e[2])  exp_instr++;
         @(posedge clk);
         #1;
         i++;
      end
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_cycle_cnt"}, cycle_cnt, 32'(exp_cycles));
      check({tag, "_instr_cnt"}, instr_cnt, 32'(exp_instr));
   endtask

   initial begin
      V_IF        = cw(1, 2'b00, 1, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
      V_IF_ST     = cw(0, 2'b00, 0, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
      V_ID        = cw(0, 2'b00, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
      V_ID_ILL    = cw(0, 2'b00, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0, 1, 1, 0);
      V_EXE_R     = cw(0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0);
      V_EXE_ADD   = cw(0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
      V_EXE_ORI   = cw(0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 2'b11, 0, 0, 0, 0, 0, 0);
      V_EXE_M     = cw(0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
      V_BR_T      = cw(1, 2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 0, 0, 1, 0, 0);
      V_BR_N      = cw(0, 2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 0, 0, 1, 0, 0);
      V_J         = cw(1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0);
      V_MEM_RD    = cw(0, 2'b00, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
      V_MEM_WR    = cw(0, 2'b00, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0);
      V_MEM_WR_ST = cw(0, 2'b00, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
      V_WB_R      = cw(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1, 1, 0, 0);
      V_WB_I      = cw(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0);
      V_WB_LD     = cw(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1, 1, 0, 0);
      V_HALT      = cw(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);

      reset = 1'b1; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check("rst_outputs", 32'(obs_cw), 32'd0);
      check_counts("rst");
      reset = 1'b0;
      #1;
      check("post_rst_if", 32'(obs_cw), 32'(V_IF));

      // R-type; a later opcode change must not alter the sequence
      opcode = 6'b000000;
      push_step(V_IF, 1, "r_if"); push_step(V_ID, 1, "r_id");
      push_step(V_EXE_R, 1, "r_exe"); push_step(V_WB_R, 1, "r_wb");
      drain(6'b101011, 2);
      check_counts("r");

      // lw then sw: 5 + 4 cycles
      opcode = 6'b100011;
      push_step(V_IF, 1, "lw_if"); push_step(V_ID, 1, "lw_id"); push_step(V_EXE_M, 1, "lw_exe");
      push_step(V_MEM_RD, 1, "lw_mem"); push_step(V_WB_LD, 1, "lw_wb");
      drain(6'b000000, -1);
      opcode = 6'b101011;
      push_step(V_IF, 1, "sw_if"); push_step(V_ID, 1, "sw_id"); push_step(V_EXE_M, 1, "sw_exe");
      push_step(V_MEM_WR, 1, "sw_mem");
      drain(6'b000000, -1);
      check_counts("lw_sw");

      // addi with opcode switched to ori during EXE, then a real ori
      opcode = 6'b001000;
      push_step(V_IF, 1, "addi_if"); push_step(V_ID, 1, "addi_id");
      push_step(V_EXE_ADD, 1, "addi_exe"); push_step(V_WB_I, 1, "addi_wb");
      drain(6'b001101, 2);
      opcode = 6'b001101;
      push_step(V_IF, 1, "ori_if"); push_step(V_ID, 1, "ori_id");
      push_step(V_EXE_ORI, 1, "ori_exe"); push_step(V_WB_I, 1, "ori_wb");
      drain(6'b000000, -1);

      // Branches over both zero values, then jump
      opcode = 6'b000100; zero = 1'b1;
      push_step(V_IF, 1, "beq_z1_if"); push_step(V_ID, 1, "beq_z1_id"); push_step(V_BR_T, 1, "beq_z1_exe");
      drain(6'b000000, -1);
      opcode = 6'b000101; zero = 1'b1;
      push_step(V_IF, 1, "bne_z1_if"); push_step(V_ID, 1, "bne_z1_id"); push_step(V_BR_N, 1, "bne_z1_exe");
      drain(6'b000000, -1);
      opcode = 6'b000100; zero = 1'b0;
      push_step(V_IF, 1, "beq_z0_if"); push_step(V_ID, 1, "beq_z0_id"); push_step(V_BR_N, 1, "beq_z0_exe");
      drain(6'b000000, -1);
      opcode = 6'b000101; zero = 1'b0;
      push_step(V_IF, 1, "bne_z0_if"); push_step(V_ID, 1, "bne_z0_id"); push_step(V_BR_T, 1, "bne_z0_exe");
      drain(6'b000000, -1);
      opcode = 6'b000010;
      push_step(V_IF, 1, "j_if"); push_step(V_ID, 1, "j_id"); push_step(V_J, 1, "j_exe");
      drain(6'b000000, -1);
      check_counts("ctl");

`ifdef MC_CTRL_STALL_EN
      // lw held 3 cycles in MEM_RD: 8 cycles, a single write-back
      opcode = 6'b100011;
      push_step(V_IF, 1, "lwst_if"); push_step(V_ID, 1, "lwst_id"); push_step(V_EXE_M, 1, "lwst_exe");
      push_step(V_MEM_RD, 0, "lwst_mem0"); push_step(V_MEM_RD, 0, "lwst_mem1");
      push_step(V_MEM_RD, 0, "lwst_mem2"); push_step(V_MEM_RD, 1, "lwst_mem3");
      push_step(V_WB_LD, 1, "lwst_wb");
      drain(6'b000000, -1);
      opcode = 6'b101011;
      push_step(V_IF_ST, 0, "swst_if0"); push_step(V_IF, 1, "swst_if1"); push_step(V_ID, 1, "swst_id");
      push_step(V_EXE_M, 1, "swst_exe"); push_step(V_MEM_WR_ST, 0, "swst_mem0");
      push_step(V_MEM_WR, 1, "swst_mem1");
      drain(6'b000000, -1);
      check_counts("stall");
`else
      // mem_ready is ignored: lw still takes 5 cycles with it low
      opcode = 6'b100011;
      push_step(V_IF, 0, "lwnr_if"); push_step(V_ID, 0, "lwnr_id"); push_step(V_EXE_M, 0, "lwnr_exe");
      push_step(V_MEM_RD, 0, "lwnr_mem"); push_step(V_WB_LD, 0, "lwnr_wb");
      drain(6'b000000, -1);
      check_counts("noready");
`endif

      // Reset while in WB_R abandons the write
      opcode = 6'b000000;
      push_step(V_IF, 1, "rr_if"); push_step(V_ID, 1, "rr_id"); push_step(V_EXE_R, 1, "rr_exe");
      drain(6'b000000, -1);
      reset = 1'b1;
      #1;
      check("rst_wb_reg_write", 32'(reg_write), 32'd0);
      check("rst_wb_outputs", 32'(obs_cw), 32'd0);
      @(posedge clk); #1;
      check("rst_hold_outputs", 32'(obs_cw), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      exp_cycles = 0; exp_instr = 0;
      #1;
      check("rst_mid_if", 32'(obs_cw), 32'(V_IF));
      check_counts("rst_mid");

      // Illegal opcode is a 2-cycle NOP, then halt freezes everything
      opcode = 6'b010101;
      push_step(V_IF, 1, "ill_if"); push_step(V_ID_ILL, 1, "ill_id");
      drain(6'b000000, -1);
      opcode = 6'b111111;
      push_step(V_IF, 1, "halt_if"); push_step(V_ID, 1, "halt_id");
      for (int k = 0; k < 20; k++) push_step(V_HALT, 1, "halt_park");
      drain(6'b000000, 5);
      check_counts("halt");

      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("halt_exit_if", 32'(obs_cw), 32'(V_IF));
      check("halt_exit_cycle_cnt", cycle_cnt, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
